prv32_div_seq: RTL

- Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU.
- Has no subtractor of its own. It borrows the core's shared ALU and drives its a/b/alufn inputs while busy, using the ALU subtract result and carry-out.
- Sits beside the execute stage. The core muxes ALU inputs to this block while alu_own=1 and stalls the pipeline while busy=1.

---
 rtl/prv32_div_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/prv32_div_seq.sv
// Sequential RV32M DIV/DIVU/REM/REMU engine that borrows the core's shared ALU subtractor.
// Optional macro PRV32_DIV_FAST_UNSIGNED_EN: unsigned ops skip the negate/fix states.
module prv32_div_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_own,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_alufn,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cf
);

  localparam int CW = $clog2(ITER);
  localparam logic [3:0] FN_SUB = 4'b0001;

  typedef enum logic [2:0] {S_IDLE, S_NEG_A, S_NEG_B, S_DIV, S_FIX, S_DONE} state_t;

  state_t          state, nstate;
  logic [XLEN-1:0] dvd, dvs, quo, rem;
  logic            neg_q, neg_r;
  logic [1:0]      op_q;
  logic [CW-1:0]   cnt;

  logic            sgn_q, take, last, fast_u, fast_end, fix_neg;
  logic [XLEN:0]   s;
  logic [XLEN-1:0] rem_nx, quo_nx;

`ifdef PRV32_DIV_FAST_UNSIGNED_EN
  assign fast_u   = op[0];
  assign fast_end = op_q[0];
`else
  assign fast_u   = 1'b0;
  assign fast_end = 1'b0;
`endif

  assign sgn_q   = ~op_q[0];
  assign s       = {rem, quo[XLEN-1]};
  assign take    = s[XLEN] | alu_cf;
  // s[XLEN] is consumed by take in the same cycle, so the stored remainder needs only XLEN bits
  assign rem_nx  = take ? alu_r : s[XLEN-1:0];
  assign quo_nx  = {quo[XLEN-2:0], take};
  assign last    = (cnt == CW'(ITER-1));
  assign fix_neg = op_q[1] ? neg_r : neg_q;
  assign alu_own = busy;
  assign done    = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate    = state;
    busy      = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_alufn = 4'b0000;
    case (state)
      S_IDLE, S_DONE: begin
        if (!start)         nstate = S_IDLE;
        else if (rs2 == '0) nstate = S_DONE;
        else if (fast_u)    nstate = S_DIV;
        else                nstate = S_NEG_A;
      end
      S_NEG_A: begin
        busy = 1'b1; alu_alufn = FN_SUB; alu_b = dvd;
        nstate = S_NEG_B;
      end
      S_NEG_B: begin
        busy = 1'b1; alu_alufn = FN_SUB; alu_b = dvs;
        nstate = S_DIV;
      end
      S_DIV: begin
        busy = 1'b1; alu_alufn = FN_SUB;
        alu_a = s[XLEN-1:0]; alu_b = dvs;
        if (last) nstate = fast_end ? S_DONE : S_FIX;
      end
      S_FIX: begin
        busy = 1'b1; alu_alufn = FN_SUB;
        alu_b = op_q[1] ? rem : quo;
        nstate = S_DONE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd <= '0; dvs <= '0; quo <= '0; rem <= '0; cnt <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; op_q <= 2'b00; result <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          op_q  <= op;
          dvd   <= rs1;
          dvs   <= rs2;
          quo   <= rs1;
          rem   <= '0;
          cnt   <= '0;
          neg_q <= ~op[0] & (rs1[XLEN-1] ^ rs2[XLEN-1]);
          neg_r <= ~op[0] & rs1[XLEN-1];
          if (rs2 == '0) result <= op[1] ? rs1 : '1;
        end
        S_NEG_A: if (sgn_q && dvd[XLEN-1]) dvd <= alu_r;
        S_NEG_B: begin
          if (sgn_q && dvs[XLEN-1]) dvs <= alu_r;
          quo <= dvd;
          rem <= '0;
          cnt <= '0;
        end
        S_DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (fast_end && last) result <= op_q[1] ? rem_nx : quo_nx;
        end
        S_FIX: result <= fix_neg ? alu_r : alu_b;
        default: ;
      endcase
    end
  end

endmodule
